// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button front-end: per-channel debounce
// FSM state encodings and the default timing constants used by both the
// channel and the top level.
package button_conditioner_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    BC_RELEASED     = 2'd0,
    BC_PRESS_WAIT   = 2'd1,
    BC_PRESSED      = 2'd2,
    BC_RELEASE_WAIT = 2'd3
  } bc_state_e;

  // 10 ms at 50 MHz: long enough to ride out contact bounce.
  localparam int unsigned BC_DB_CYCLES_DEFAULT   = 500000;
  // 1 s at 50 MHz before a held button counts as a long press.
  localparam int unsigned BC_HOLD_CYCLES_DEFAULT = 50000000;

endpackage : button_conditioner_pkg

// File: rtl/button_debounce_channel.sv
// One push-button channel: 2-FF synchroniser, debounce FSM with a stability
// counter, registered press/release pulses and a clean level.
// Build option: define LONG_PRESS_EN to add a hold counter and long_pulse;
// otherwise o_long_pulse is tied low and no hold counter exists.
module button_debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = BC_DB_CYCLES_DEFAULT,
  parameter int unsigned HOLD_CYCLES = BC_HOLD_CYCLES_DEFAULT
) (
  input  logic fpgaclock,
  input  logic reset,
  input  logic i_enable,
  input  logic i_btn_raw,
  output logic o_level,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_long_pulse
);

  // Counter only has to reach DB_CYCLES-1, so it can never wrap.
  localparam int unsigned     CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Reject impossible timing at elaboration rather than build a broken counter.
  if (DB_CYCLES < 2 || HOLD_CYCLES < 1) begin : g_bad_params
    $error("button_debounce_channel: need DB_CYCLES >= 2 and HOLD_CYCLES >= 1");
  end

  logic             r_sync1;
  logic             r_sync2;
  bc_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press_pulse;
  logic             r_release_pulse;

  bc_state_e        w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_level_next;
  logic             w_press_next;
  logic             w_release_next;

  // Two-stage synchroniser for the asynchronous button input.
  always_ff @(posedge fpgaclock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would collapse the two
    // synchroniser stages into one.
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state, stability counter, level and pulse registers.
  always_ff @(posedge fpgaclock) begin
    if (reset) begin
      r_state         <= BC_RELEASED;
      r_cnt           <= '0;
      r_level         <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_cnt           <= w_cnt_next;
      r_level         <= w_level_next;
      r_press_pulse   <= w_press_next;
      r_release_pulse <= w_release_next;
    end
  end

  // Next-state logic: a level change is accepted only after DB_CYCLES
  // consecutive agreeing samples; any disagreeing sample aborts the count.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_level_next   = r_level;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    case (r_state)
      BC_RELEASED: begin
        if (r_sync2) begin
          w_state_next = BC_PRESS_WAIT;
          w_cnt_next   = CNT_ONE;
        end
      end
      BC_PRESS_WAIT: begin
        if (!r_sync2) begin
          w_state_next = BC_RELEASED;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = BC_PRESSED;
          w_cnt_next   = '0;
          w_level_next = 1'b1;
          w_press_next = i_enable;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      BC_PRESSED: begin
        if (!r_sync2) begin
          w_state_next = BC_RELEASE_WAIT;
          w_cnt_next   = CNT_ONE;
        end
      end
      BC_RELEASE_WAIT: begin
        if (r_sync2) begin
          w_state_next = BC_PRESSED;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next   = BC_RELEASED;
          w_cnt_next     = '0;
          w_level_next   = 1'b0;
          w_release_next = i_enable;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_next = BC_RELEASED;
        w_cnt_next   = '0;
      end
    endcase
  end

`ifdef LONG_PRESS_EN
  localparam int unsigned      HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_long_pulse;

  // Hold counter: restarts on a fresh press, parks at HOLD_CYCLES after
  // firing so long_pulse fires at most once; an aborted release keeps it.
  always_ff @(posedge fpgaclock) begin
    if (reset) begin
      r_hold_cnt   <= '0;
      r_long_pulse <= 1'b0;
    end else begin
      r_long_pulse <= 1'b0;
      if (r_state == BC_PRESS_WAIT && w_state_next == BC_PRESSED) begin
        r_hold_cnt <= '0;
      end else if ((r_state == BC_PRESSED || r_state == BC_RELEASE_WAIT) &&
                   r_hold_cnt != HOLD_MAX) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        if (r_hold_cnt == HOLD_LAST) begin
          r_long_pulse <= i_enable;
        end
      end
    end
  end

  assign o_long_pulse = r_long_pulse;
`else
  assign o_long_pulse = 1'b0;
`endif

  assign o_level         = r_level;
  assign o_press_pulse   = r_press_pulse;
  assign o_release_pulse = r_release_pulse;

endmodule : button_debounce_channel

// File: rtl/button_conditioner.sv
// Push-button front-end for the run-control FSM: one independent debounce
// channel per button (bit0 start, bit1 interrupt, bit2 reset request).
// Build option: define LONG_PRESS_EN to enable long_pulse generation.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned NUM_BTN     = 3,
  parameter int unsigned DB_CYCLES   = BC_DB_CYCLES_DEFAULT,
  parameter int unsigned HOLD_CYCLES = BC_HOLD_CYCLES_DEFAULT
) (
  input  logic               fpgaclock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    button_debounce_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_channel (
      .fpgaclock      (fpgaclock),
      .reset          (reset),
      .i_enable       (enable),
      .i_btn_raw      (btn_raw[g]),
      .o_level        (btn_level[g]),
      .o_press_pulse  (press_pulse[g]),
      .o_release_pulse(release_pulse[g]),
      .o_long_pulse   (long_pulse[g])
    );
  end

endmodule : button_conditioner
